// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: shared types, defaults and helpers for the hazard sequencer.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RESET    = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } hazard_state_e;

    localparam int MEM_TIMEOUT_DEF     = 255;
    localparam int RST_SYNC_CYCLES_DEF = 2;

    typedef struct packed {
        logic stall_n_if;
        logic stall_n_id;
        logic stall_n_ex;
        logic flush_id;
        logic flush_ex;
        logic pc_redirect;
    } ctrl_t;

    localparam ctrl_t CTRL_HALT   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam ctrl_t CTRL_JUMP   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    localparam ctrl_t CTRL_BUBBLE = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    function automatic logic load_use_hit(
        input logic [4:0] rs1_addr,
        input logic [4:0] rs2_addr,
        input logic       rs1_used,
        input logic       rs2_used,
        input logic [4:0] rd_addr,
        input logic       reg_wen,
        input logic       is_load
    );
        return is_load && reg_wen && (rd_addr != 5'd0) &&
               ((rs1_used && rs1_addr == rd_addr) || (rs2_used && rs2_addr == rd_addr));
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
        return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_rst_synchronizer.sv
// rst_synchronizer: async-assert, sync-release reset with a DEPTH-edge release delay.
module rst_synchronizer #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic rst_sync,
    output logic expire
);

    logic [DEPTH-1:0] sr;
    logic [DEPTH-1:0] sr_next;

    assign sr_next = sr << 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr <= '1;
        else        sr <= sr_next;
    end

    assign rst_sync = sr[DEPTH-1];
    // High on the edge that will drop rst_sync, so the FSM leaves RESET in step with it.
    assign expire   = !sr_next[DEPTH-1];

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for load-use, EX redirects and RAM waits,
// with a RAM-wait watchdog and saturating performance counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT     = MEM_TIMEOUT_DEF,
    parameter int RST_SYNC_CYCLES = RST_SYNC_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rs1_addr_id,
    input  logic [4:0]  rs2_addr_id,
    input  logic        rs1_used_id,
    input  logic        rs2_used_id,
    input  logic [4:0]  rd_addr_ex,
    input  logic        reg_wen_ex,
    input  logic        ram_load_access_ex,
    input  logic        jump_ex,
    input  logic [31:0] jump_addr_ex,
    input  logic        ram_req_mem,
    input  logic        ram_ready,
    output logic        rst_sync,
    output logic        stall_n_if,
    output logic        stall_n_id,
    output logic        stall_n_ex,
    output logic        flush_id,
    output logic        flush_ex,
    output logic        pc_redirect,
    output logic [31:0] pc_target,
    output logic        mem_timeout_err,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WW-1:0] WD_MAX = WW'(MEM_TIMEOUT);

    hazard_state_e state;
    hazard_state_e state_next;
    ctrl_t         ctrl;
    logic          sync_expire;
    logic          load_use;
    logic          freeze;
    logic          any_stall;
    logic [WW-1:0] wd_cnt;
    logic [WW-1:0] wd_next;

    rst_synchronizer #(.DEPTH(RST_SYNC_CYCLES)) u_rst_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .rst_sync (rst_sync),
        .expire   (sync_expire)
    );

    assign load_use = load_use_hit(rs1_addr_id, rs2_addr_id, rs1_used_id, rs2_used_id,
                                   rd_addr_ex, reg_wen_ex, ram_load_access_ex);

    // A ready RAM in MEM_WAIT releases the pipeline in that same cycle.
    assign freeze = !ram_ready && (state == MEM_WAIT || (state == RUN && ram_req_mem));

    always_comb begin
        state_next = state;
        state_next = (state == RESET) ? (sync_expire ? RUN : RESET) :
                     (state == RUN)   ? ((ram_req_mem && !ram_ready) ? MEM_WAIT : RUN) :
                                        (ram_ready ? RUN : MEM_WAIT);
    end

    always_comb begin
        ctrl = CTRL_HALT;
        if (!(state == RESET || rst_sync || freeze))
            ctrl = jump_ex ? CTRL_JUMP : (load_use ? CTRL_BUBBLE : CTRL_RUN);
    end

    assign stall_n_if  = ctrl.stall_n_if;
    assign stall_n_id  = ctrl.stall_n_id;
    assign stall_n_ex  = ctrl.stall_n_ex;
    assign flush_id    = ctrl.flush_id;
    assign flush_ex    = ctrl.flush_ex;
    assign pc_redirect = ctrl.pc_redirect;
    assign pc_target   = ctrl.pc_redirect ? jump_addr_ex : 32'd0;

    assign any_stall = (state != RESET) && !(ctrl.stall_n_if && ctrl.stall_n_id && ctrl.stall_n_ex);
    assign wd_next   = freeze ? ((wd_cnt == WD_MAX) ? wd_cnt : wd_cnt + 1'b1) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= RESET;
            wd_cnt          <= '0;
            mem_timeout_err <= 1'b0;
            stall_cycles    <= 32'd0;
            flush_count     <= 32'd0;
        end else begin
            state           <= state_next;
            wd_cnt          <= wd_next;
            mem_timeout_err <= mem_timeout_err || (wd_next == WD_MAX);
            stall_cycles    <= sat_inc32(stall_cycles, any_stall);
            flush_count     <= sat_inc32(flush_count, ctrl.pc_redirect);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: table vectors, directed corner sequences and random stimulus
// checked against a cycle-level behavioural model of the sequencer.
module tb_pipeline_hazard_ctrl;

    localparam int MT = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  rs1_addr_id, rs2_addr_id, rd_addr_ex;
    logic        rs1_used_id, rs2_used_id, reg_wen_ex, ram_load_access_ex, jump_ex;
    logic [31:0] jump_addr_ex;
    logic        ram_req_mem, ram_ready;
    logic        rst_sync, stall_n_if, stall_n_id, stall_n_ex, flush_id, flush_ex, pc_redirect;
    logic [31:0] pc_target, stall_cycles, flush_count;
    logic        mem_timeout_err;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(MT), .RST_SYNC_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_addr_id(rs1_addr_id), .rs2_addr_id(rs2_addr_id),
        .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
        .rd_addr_ex(rd_addr_ex), .reg_wen_ex(reg_wen_ex),
        .ram_load_access_ex(ram_load_access_ex), .jump_ex(jump_ex),
        .jump_addr_ex(jump_addr_ex), .ram_req_mem(ram_req_mem), .ram_ready(ram_ready),
        .rst_sync(rst_sync), .stall_n_if(stall_n_if), .stall_n_id(stall_n_id),
        .stall_n_ex(stall_n_ex), .flush_id(flush_id), .flush_ex(flush_ex),
        .pc_redirect(pc_redirect), .pc_target(pc_target),
        .mem_timeout_err(mem_timeout_err), .stall_cycles(stall_cycles),
        .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    int          m_rst_left;
    bit          m_wait;
    int          m_wcnt;
    bit          m_err;
    logic [31:0] m_stall, m_flush;

    typedef struct {
        logic [4:0]  rs1, rs2, rd;
        logic        u1, u2, wen, ld, jmp;
        logic [31:0] tgt;
        logic [5:0]  ectl;
        logic [31:0] etgt;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [5:0] ctl_now();
        return {stall_n_if, stall_n_id, stall_n_ex, flush_id, flush_ex, pc_redirect};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        rs1_addr_id = 0; rs2_addr_id = 0; rd_addr_ex = 0;
        rs1_used_id = 0; rs2_used_id = 0; reg_wen_ex = 0; ram_load_access_ex = 0;
        jump_ex = 0; jump_addr_ex = 0; ram_req_mem = 0; ram_ready = 0;
    endtask

    // One clock: check outputs mid-cycle against the model, then advance model and clock.
    task automatic cycle(input string tag);
        bit rs, lu, frz;
        logic [5:0] ectl;
        logic [31:0] etgt;
        #3;
        rs  = m_rst_left > 0;
        lu  = ram_load_access_ex && reg_wen_ex && rd_addr_ex != 0 &&
              ((rs1_used_id && rs1_addr_id == rd_addr_ex) || (rs2_used_id && rs2_addr_id == rd_addr_ex));
        frz = !rs && !ram_ready && (m_wait || ram_req_mem);
        if (rs || frz)    ectl = 6'b000000;
        else if (jump_ex) ectl = 6'b111111;
        else if (lu)      ectl = 6'b001010;
        else              ectl = 6'b111000;
        etgt = ectl[0] ? jump_addr_ex : 32'd0;
        chk({tag, ".rst_sync"}, rst_sync, rs);
        chk({tag, ".ctl"}, ctl_now(), ectl);
        chk({tag, ".pc_target"}, pc_target, etgt);
        chk({tag, ".err"}, mem_timeout_err, m_err);
        chk({tag, ".stall_cycles"}, stall_cycles, m_stall);
        chk({tag, ".flush_count"}, flush_count, m_flush);
        @(posedge clk); #1;
        if (rs) m_rst_left--;
        else begin
            if (ectl[5:3] != 3'b111 && m_stall != 32'hFFFF_FFFF) m_stall++;
            if (ectl[0] && m_flush != 32'hFFFF_FFFF) m_flush++;
            m_wait = frz;
            m_wcnt = frz ? ((m_wcnt < MT) ? m_wcnt + 1 : MT) : 0;
            if (m_wcnt == MT) m_err = 1;
        end
    endtask

    task automatic apply_reset(input int ncyc);
        rst_n = 1'b0;
        #1;
        chk("async.rst_sync", rst_sync, 1);
        chk("async.ctl", ctl_now(), 0);
        chk("async.pc_target", pc_target, 0);
        chk("async.err", mem_timeout_err, 0);
        chk("async.stall_cycles", stall_cycles, 0);
        chk("async.flush_count", flush_count, 0);
        m_rst_left = 2; m_wait = 0; m_wcnt = 0; m_err = 0; m_stall = 0; m_flush = 0;
        repeat (ncyc) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] s0, f0;
        idle();
        m_rst_left = 2; m_wait = 0; m_wcnt = 0; m_err = 0; m_stall = 0; m_flush = 0;
        @(posedge clk); #1;
        apply_reset(3);
        cycle("rel0");
        cycle("rel1");
        cycle("rel2");
        chk("rel.stall_n", {stall_n_if, stall_n_id, stall_n_ex}, 3'b111);
        chk("rel.stall_cycles", stall_cycles, 0);

        tbl.push_back('{5, 0, 5, 1, 0, 1, 1, 0, 0, 6'b001010, 0});
        tbl.push_back('{0, 0, 0, 1, 0, 1, 1, 0, 0, 6'b111000, 0});
        tbl.push_back('{1, 7, 7, 0, 1, 1, 1, 0, 0, 6'b001010, 0});
        tbl.push_back('{1, 7, 7, 0, 0, 1, 1, 0, 0, 6'b111000, 0});
        tbl.push_back('{9, 0, 9, 1, 0, 1, 0, 0, 0, 6'b111000, 0});
        tbl.push_back('{9, 0, 9, 1, 0, 0, 1, 0, 0, 6'b111000, 0});
        tbl.push_back('{5, 0, 5, 1, 0, 1, 1, 1, 32'h100, 6'b111111, 32'h100});
        tbl.push_back('{3, 4, 6, 1, 1, 1, 1, 1, 32'hDEAD_BEE0, 6'b111111, 32'hDEAD_BEE0});
        tbl.push_back('{5, 5, 6, 1, 1, 1, 1, 0, 32'h44, 6'b111000, 0});
        foreach (tbl[i]) begin
            rs1_addr_id = tbl[i].rs1; rs2_addr_id = tbl[i].rs2; rd_addr_ex = tbl[i].rd;
            rs1_used_id = tbl[i].u1; rs2_used_id = tbl[i].u2; reg_wen_ex = tbl[i].wen;
            ram_load_access_ex = tbl[i].ld; jump_ex = tbl[i].jmp; jump_addr_ex = tbl[i].tgt;
            #3;
            chk($sformatf("tbl%0d.ctl", i), ctl_now(), tbl[i].ectl);
            chk($sformatf("tbl%0d.tgt", i), pc_target, tbl[i].etgt);
            cycle($sformatf("tbl%0d", i));
            idle();
        end

        s0 = stall_cycles; f0 = flush_count;
        rs1_addr_id = 5; rs1_used_id = 1; rd_addr_ex = 5; reg_wen_ex = 1; ram_load_access_ex = 1;
        cycle("lu.bubble");
        idle();
        cycle("lu.after");
        chk("lu.stall_delta", stall_cycles - s0, 1);

        f0 = flush_count;
        rs1_addr_id = 2; rs1_used_id = 1; rd_addr_ex = 2; reg_wen_ex = 1; ram_load_access_ex = 1;
        jump_ex = 1; jump_addr_ex = 32'h100;
        cycle("jh");
        chk("jh.flush_delta", flush_count - f0, 1);
        idle();

        s0 = stall_cycles; f0 = flush_count;
        jump_ex = 1; jump_addr_ex = 32'h200; ram_req_mem = 1; ram_ready = 0;
        for (int i = 0; i < 4; i++) begin
            #3;
            chk("rw.freeze", ctl_now(), 0);
            cycle("rw.wait");
        end
        ram_ready = 1;
        #3;
        chk("rw.redirect", {pc_redirect, pc_target}, {1'b1, 32'h200});
        cycle("rw.ready");
        idle();
        chk("rw.stall_delta", stall_cycles - s0, 4);
        chk("rw.flush_delta", flush_count - f0, 1);
        cycle("rw.idle");

        ram_req_mem = 1; ram_ready = 0;
        for (int i = 0; i < 10; i++) cycle($sformatf("wd%0d", i));
        ram_ready = 1;
        cycle("wd.ready");
        idle();
        cycle("wd.after");
        chk("wd.sticky", mem_timeout_err, 1);

        ram_req_mem = 1; ram_ready = 0;
        cycle("mr.w0");
        cycle("mr.w1");
        apply_reset(1);
        idle();
        cycle("mr.rel0");
        cycle("mr.rel1");
        cycle("mr.run");

        for (int i = 0; i < 400; i++) begin
            rs1_addr_id = 5'($urandom_range(0, 3)); rs2_addr_id = 5'($urandom_range(0, 3));
            rd_addr_ex = 5'($urandom_range(0, 3));
            rs1_used_id = 1'($urandom); rs2_used_id = 1'($urandom);
            reg_wen_ex = 1'($urandom); ram_load_access_ex = 1'($urandom);
            jump_ex = ($urandom_range(0, 3) == 0); jump_addr_ex = $urandom & 32'hFFFF_FFFC;
            ram_req_mem = ($urandom_range(0, 2) == 0); ram_ready = ($urandom_range(0, 2) != 0);
            cycle($sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the five-stage RV32I core. It drives the `stall_n`, `flush` and `rst_sync` inputs of the IF/ID and ID/EX pipeline registers. It detects load-use hazards, EX-stage jump redirects and multi-cycle data-RAM waits. It also watchdogs RAM waits and keeps saturating stall and flush performance counters.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 255: maximum consecutive RAM wait cycles before `mem_timeout_err` asserts; width is `$clog2(MEM_TIMEOUT+1)`.
- `RST_SYNC_CYCLES`, default 2: cycles `rst_sync` stays high after `rst_n` deasserts.

Ports:
- `clk` in 1: core clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `rs1_addr_id` in 5: rs1 index of the instruction in ID.
- `rs2_addr_id` in 5: rs2 index of the instruction in ID.
- `rs1_used_id` in 1: ID instruction reads rs1.
- `rs2_used_id` in 1: ID instruction reads rs2.
- `rd_addr_ex` in 5: rd index of the instruction in EX.
- `reg_wen_ex` in 1: EX instruction writes rd.
- `ram_load_access_ex` in 1: EX instruction is a load.
- `jump_ex` in 1: EX resolved a taken branch or jump.
- `jump_addr_ex` in 32: redirect target.
- `ram_req_mem` in 1: MEM stage has a RAM access in flight.
- `ram_ready` in 1: RAM completes the access this cycle.
- `rst_sync` out 1: synchronous reset to the pipeline registers.
- `stall_n_if` out 1: PC register enable.
- `stall_n_id` out 1: IF/ID register enable.
- `stall_n_ex` out 1: ID/EX register enable.
- `flush_id` out 1: IF/ID flush.
- `flush_ex` out 1: ID/EX flush.
- `pc_redirect` out 1: load `pc_target` into the PC.
- `pc_target` out 32: redirect target.
- `mem_timeout_err` out 1: sticky watchdog error.
- `stall_cycles` out 32: saturating count of stall cycles.
- `flush_count` out 32: saturating count of redirects.

## Operation
- **Reset synchronizer.** `rst_n` low sets `rst_sync`=1 asynchronously. After `rst_n` deasserts, `rst_sync` stays 1 for `RST_SYNC_CYCLES` rising edges, then drops.
- **FSM states:** RESET, RUN, MEM_WAIT.
  - RESET → RUN when the synchronizer count expires.
  - RUN → MEM_WAIT when `ram_req_mem` && !`ram_ready`.
  - MEM_WAIT → RUN when `ram_ready`=1.
- **Load-use hazard:** `load_use` = `ram_load_access_ex` && `reg_wen_ex` && `rd_addr_ex`≠0 && ((`rs1_used_id` && `rs1_addr_id`==`rd_addr_ex`) || (`rs2_used_id` && `rs2_addr_id`==`rd_addr_ex`)).
- **Combinational decode, in priority order:**
  1. RESET state, or `rst_sync`=1: all `stall_n_*`=0, all `flush_*`=0, `pc_redirect`=0.
  2. Memory wait. Condition: MEM_WAIT, or RUN with `ram_req_mem` && !`ram_ready`. All `stall_n_*`=0, no flush, no redirect. A pending jump or hazard is held by the frozen pipeline and re-evaluated when the freeze lifts.
  3. `jump_ex`: `pc_redirect`=1, `pc_target`=`jump_addr_ex`, `flush_id`=1, `flush_ex`=1, all `stall_n_*`=1. A simultaneous load-use is ignored, because the ID instruction is squashed.
  4. `load_use`: `stall_n_if`=0, `stall_n_id`=0, `stall_n_ex`=1, `flush_ex`=1. This inserts one bubble.
  5. Otherwise: all `stall_n_*`=1, no flush, no redirect.
- **`pc_target`:** when `pc_redirect`=0, `pc_target` = 0.
- **Watchdog:**
  - The counter increments on every MEM_WAIT cycle and clears when `ram_ready`=1 or on entry to RUN.
  - When the counter reaches `MEM_TIMEOUT`, `mem_timeout_err` sets and stays set until reset.
  - The stall continues after the error; it does not unblock the pipeline.
- **Performance counters:**
  - `stall_cycles` increments in every cycle where any `stall_n_*`=0 and the FSM is not in RESET.
  - `flush_count` increments in every cycle with `pc_redirect`=1.
  - Both counters saturate at 0xFFFF_FFFF.

## Timing
- **Reset values:**
  - `rst_sync`=1, FSM=RESET.
  - All `stall_n_*`=0, all `flush_*`=0, `pc_redirect`=0, `pc_target`=0.
  - `mem_timeout_err`=0, both counters 0.
- **Output latency:** stall, flush and redirect outputs are combinational, with zero-cycle latency from their inputs. FSM state, counters and `rst_sync` are registered and update on the rising edge.
- **Load-use:** exactly one bubble. In the following cycle the load sits in MEM, so `load_use` deasserts by construction.
- **RAM completion:** `ram_ready` arriving in the same cycle as `ram_req_mem` causes no stall. The first stalled cycle is the first cycle with `ram_req_mem`=1 && `ram_ready`=0. The pipeline resumes in the cycle `ram_ready`=1.
- **Reset mid-operation:** asserting `rst_n` during MEM_WAIT or during a redirect immediately forces the reset outputs.

## Structure
- **`RV32I_Inst_Pkg`:** add a `hazard_state_e` enum (RESET, RUN, MEM_WAIT). Defaults for `MEM_TIMEOUT` and `RST_SYNC_CYCLES` go here as localparams.
- **Sub-module `rst_synchronizer`:** asynchronous assert, synchronous release, parameterised depth. Drives `rst_sync` and the RESET exit.
- **Main module:** the remaining logic, with counters inline.

## Test plan
- **Reset release:** hold `rst_n`=0 for 3 cycles, then release. Expect `rst_sync`=1 for exactly 2 edges after release, then all `stall_n_*`=1 and counters at 0.
- **Load-use:** load writing x5 in EX; ID uses x5 as rs1. Expect a one-cycle `stall_n_if`=`stall_n_id`=0 and `flush_ex`=1, then normal flow; `stall_cycles`=1. Repeat with rd=x0: expect no stall.
- **Jump plus hazard:** `jump_ex`=1 with `jump_addr_ex`=0x0000_0100 and a coincident load-use. Expect `pc_redirect`=1, `pc_target`=0x100, `flush_id`=`flush_ex`=1, all `stall_n`=1; `flush_count`=1.
- **RAM wait with pending jump:** `ram_req_mem`=1 with `ram_ready` low for 4 cycles while `jump_ex`=1. Expect a 4-cycle full freeze with no redirect. Redirect occurs in the `ram_ready` cycle; `stall_cycles`=4.
- **Watchdog:** with `MEM_TIMEOUT`=8, hold `ram_ready`=0 for 10 cycles. Expect `mem_timeout_err` high from the 8th wait cycle, staying high after `ram_ready` returns.
- **Mid-wait reset:** assert `rst_n`=0 during MEM_WAIT. Expect immediate `rst_sync`=1, FSM=RESET, and counters and error cleared.
